// File: rtl/mag_comp_tracker.sv
// mag_comp_tracker: statistics tracker for a 4-bit magnitude comparator.
// It counts each comparator outcome, keeps the largest winning operand, and
// tracks runs of identical outcomes, raising an alarm when a run gets long.
// Optional feature: define MAG_TRK_HIST_EN to add the 8-bit 'hist' output.
// hist holds the last four accepted outcome codes, with the newest in [1:0].
//
// state  | meaning
// IDLE   | no sample accepted since reset/clear
// GT_RUN | current run is of a > b results
// LT_RUN | current run is of a < b results
// EQ_RUN | current run is of a == b results
module mag_comp_tracker #(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 8,
  parameter int RUN_LIMIT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [WIDTH-1:0] max_val,
  output logic             max_valid,
  output logic [1:0]       run_state,
  output logic [CNT_W-1:0] run_len,
  output logic             alarm,
  output logic             err
`ifdef MAG_TRK_HIST_EN
  ,
  output logic [7:0]       hist
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GT_RUN = 2'b01,
    LT_RUN = 2'b10,
    EQ_RUN = 2'b11
  } run_state_e;

  run_state_e       state_q, state_d, sample_state;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d, lt_cnt_q, lt_cnt_d, eq_cnt_q, eq_cnt_d;
  logic [WIDTH-1:0] max_q, max_d, winner;
  logic             max_valid_q, max_valid_d;
  logic             err_q, err_d;
  logic             one_hot, accept, illegal;

  // Classify the incoming sample and pick its winning operand.
  always_comb begin
    one_hot      = (a_gt_b ^ a_lt_b ^ a_eq_b) & ~(a_gt_b & a_lt_b & a_eq_b);
    accept       = in_valid & one_hot & ~clear;
    illegal      = in_valid & ~one_hot & ~clear;
    sample_state = a_gt_b ? GT_RUN : (a_lt_b ? LT_RUN : EQ_RUN);
    winner       = a_lt_b ? b : a;
  end

  // Run-length FSM next state.
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    if (clear) begin
      state_d   = IDLE;
      run_len_d = '0;
    end else if (accept) begin
      state_d = sample_state;
      if (state_q == sample_state) begin
        if (run_len_q != '1) run_len_d = run_len_q + 1'b1;
      end else begin
        run_len_d = CNT_W'(1);
      end
    end
  end

  // Run-length FSM registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      run_len_q <= '0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
    end
  end

  // Saturating counters, running maximum and sticky error next state.
  always_comb begin
    gt_cnt_d    = gt_cnt_q;
    lt_cnt_d    = lt_cnt_q;
    eq_cnt_d    = eq_cnt_q;
    max_d       = max_q;
    max_valid_d = max_valid_q;
    err_d       = err_q | illegal;
    if (clear) begin
      gt_cnt_d    = '0;
      lt_cnt_d    = '0;
      eq_cnt_d    = '0;
      max_d       = '0;
      max_valid_d = 1'b0;
    end else if (accept) begin
      if (a_gt_b && gt_cnt_q != '1) gt_cnt_d = gt_cnt_q + 1'b1;
      if (a_lt_b && lt_cnt_q != '1) lt_cnt_d = lt_cnt_q + 1'b1;
      if (a_eq_b && eq_cnt_q != '1) eq_cnt_d = eq_cnt_q + 1'b1;
      if (!max_valid_q || winner > max_q) max_d = winner;
      max_valid_d = 1'b1;
    end
  end

  // Statistics registers; err survives clear and only reset drops it.
  always_ff @(posedge clock) begin
    if (reset) begin
      gt_cnt_q    <= '0;
      lt_cnt_q    <= '0;
      eq_cnt_q    <= '0;
      max_q       <= '0;
      max_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gt_cnt_q    <= gt_cnt_d;
      lt_cnt_q    <= lt_cnt_d;
      eq_cnt_q    <= eq_cnt_d;
      max_q       <= max_d;
      max_valid_q <= max_valid_d;
      err_q       <= err_d;
    end
  end

`ifdef MAG_TRK_HIST_EN
  logic [7:0] hist_q, hist_d;

  // Outcome history shifts in the newest code at the bottom.
  always_comb begin
    hist_d = hist_q;
    if (clear) hist_d = '0;
    else if (accept) hist_d = {hist_q[5:0], sample_state};
  end

  // Outcome history register.
  always_ff @(posedge clock) begin
    if (reset) hist_q <= '0;
    else       hist_q <= hist_d;
  end

  assign hist = hist_q;
`endif

  assign gt_count  = gt_cnt_q;
  assign lt_count  = lt_cnt_q;
  assign eq_count  = eq_cnt_q;
  assign max_val   = max_q;
  assign max_valid = max_valid_q;
  assign run_state = state_q;
  assign run_len   = run_len_q;
  assign alarm     = (run_len_q >= CNT_W'(RUN_LIMIT));
  assign err       = err_q;

endmodule

// File: tb/tb_mag_comp_tracker.sv
module tb_mag_comp_tracker;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int RUN_LIMIT = 3;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset, clear, in_valid, a_gt_b, a_lt_b, a_eq_b;
  logic [WIDTH-1:0] a, b;
  logic [CNT_W-1:0] gt_count, lt_count, eq_count, run_len;
  logic [WIDTH-1:0] max_val;
  logic max_valid, alarm, err;
  logic [1:0] run_state;
`ifdef MAG_TRK_HIST_EN
  logic [7:0] hist;
`endif

  mag_comp_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RUN_LIMIT(RUN_LIMIT)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b), .a(a), .b(b),
    .gt_count(gt_count), .lt_count(lt_count), .eq_count(eq_count),
    .max_val(max_val), .max_valid(max_valid), .run_state(run_state),
    .run_len(run_len), .alarm(alarm), .err(err)
`ifdef MAG_TRK_HIST_EN
    , .hist(hist)
`endif
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: outcomes as small integers 1=gt, 2=lt, 3=eq, 0=none.
  int m_gt, m_lt, m_eq, m_max, m_run, m_len;
  bit m_mv, m_err;
  int m_hist[$];

  function automatic void model_step(bit r, bit c, bit v, bit g, bit l, bit e, int av, int bv);
    int code, win;
    if (r) begin
      m_gt = 0; m_lt = 0; m_eq = 0; m_max = 0; m_mv = 0; m_run = 0; m_len = 0;
      m_err = 0; m_hist.delete();
    end else if (c) begin
      m_gt = 0; m_lt = 0; m_eq = 0; m_max = 0; m_mv = 0; m_run = 0; m_len = 0;
      m_hist.delete();
    end else if (v) begin
      if (int'(g) + int'(l) + int'(e) == 1) begin
        code = g ? 1 : (l ? 2 : 3);
        win  = l ? bv : av;
        if (g) m_gt = (m_gt < MAXC) ? m_gt + 1 : MAXC;
        if (l) m_lt = (m_lt < MAXC) ? m_lt + 1 : MAXC;
        if (e) m_eq = (m_eq < MAXC) ? m_eq + 1 : MAXC;
        if (!m_mv || win > m_max) m_max = win;
        m_mv = 1;
        if (m_run == code) m_len = (m_len < MAXC) ? m_len + 1 : MAXC;
        else begin m_run = code; m_len = 1; end
        m_hist.push_front(code);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
      end else begin
        m_err = 1;
      end
    end
  endfunction

  function automatic int model_hist();
    int h = 0;
    for (int i = 0; i < m_hist.size(); i++) h |= m_hist[i] << (2 * i);
    return h;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".gt_count"}, gt_count, m_gt);
    chk({tag, ".lt_count"}, lt_count, m_lt);
    chk({tag, ".eq_count"}, eq_count, m_eq);
    chk({tag, ".max_val"}, max_val, m_max);
    chk({tag, ".max_valid"}, max_valid, m_mv);
    chk({tag, ".run_state"}, run_state, m_run);
    chk({tag, ".run_len"}, run_len, m_len);
    chk({tag, ".alarm"}, alarm, (m_len >= RUN_LIMIT) ? 1 : 0);
    chk({tag, ".err"}, err, m_err);
`ifdef MAG_TRK_HIST_EN
    chk({tag, ".hist"}, hist, model_hist());
`endif
  endtask

  // Drive one cycle, advance the model at the edge, settle past the edge.
  task automatic cyc(input bit r, c, v, g, l, e, input int av, bv);
    reset = r; clear = c; in_valid = v; a_gt_b = g; a_lt_b = l; a_eq_b = e;
    a = WIDTH'(av); b = WIDTH'(bv);
    @(posedge clock);
    model_step(r, c, v, g, l, e, av, bv);
    #1;
  endtask

  typedef struct {
    bit r, c, v, g, l, e;
    int av, bv;
    int x_gt, x_lt, x_eq, x_max, x_mv, x_st, x_len, x_al, x_err, x_hist;
  } vec_t;

  vec_t tbl[16];

  initial begin
    //          r c v g l e  a  b  gt lt eq max mv st len al err hist
    tbl[0]  = '{1,0,1,1,0,0,10, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00};
    tbl[1]  = '{1,0,1,1,0,0,10, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00};
    tbl[2]  = '{0,0,1,1,0,0,10, 9, 1, 0, 0,10, 1, 1, 1, 0, 0, 'h01};
    tbl[3]  = '{0,0,1,0,1,0, 1, 6, 1, 1, 0,10, 1, 2, 1, 0, 0, 'h06};
    tbl[4]  = '{0,0,1,0,1,0, 2,11, 1, 2, 0,11, 1, 2, 2, 0, 0, 'h1A};
    tbl[5]  = '{0,0,1,0,0,1,15,15, 1, 2, 1,15, 1, 3, 1, 0, 0, 'h6B};
    tbl[6]  = '{0,0,1,0,1,0, 2,11, 1, 3, 1,15, 1, 2, 1, 0, 0, 'hAE};
    tbl[7]  = '{0,0,1,0,1,0, 2,11, 1, 4, 1,15, 1, 2, 2, 0, 0, 'hBA};
    tbl[8]  = '{0,0,1,0,1,0, 2,11, 1, 5, 1,15, 1, 2, 3, 1, 0, 'hEA};
    tbl[9]  = '{0,0,1,0,0,1,15,15, 1, 5, 2,15, 1, 3, 1, 0, 0, 'hAB};
    tbl[10] = '{0,0,0,1,0,0,10, 9, 1, 5, 2,15, 1, 3, 1, 0, 0, 'hAB};
    tbl[11] = '{0,0,1,1,0,1,10, 9, 1, 5, 2,15, 1, 3, 1, 0, 1, 'hAB};
    tbl[12] = '{0,0,1,0,0,0,10, 9, 1, 5, 2,15, 1, 3, 1, 0, 1, 'hAB};
    tbl[13] = '{0,1,1,1,0,0,10, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00};
    tbl[14] = '{0,0,1,0,1,0, 3,12, 0, 1, 0,12, 1, 2, 1, 0, 1, 'h02};
    tbl[15] = '{1,0,1,0,1,0, 3,12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00};

    reset = 1; clear = 0; in_valid = 0; a_gt_b = 0; a_lt_b = 0; a_eq_b = 0; a = '0; b = '0;
    #2;

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      cyc(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].g, tbl[i].l, tbl[i].e, tbl[i].av, tbl[i].bv);
      chk({t, ".gt_count"}, gt_count, tbl[i].x_gt);
      chk({t, ".lt_count"}, lt_count, tbl[i].x_lt);
      chk({t, ".eq_count"}, eq_count, tbl[i].x_eq);
      chk({t, ".max_val"}, max_val, tbl[i].x_max);
      chk({t, ".max_valid"}, max_valid, tbl[i].x_mv);
      chk({t, ".run_state"}, run_state, tbl[i].x_st);
      chk({t, ".run_len"}, run_len, tbl[i].x_len);
      chk({t, ".alarm"}, alarm, tbl[i].x_al);
      chk({t, ".err"}, err, tbl[i].x_err);
`ifdef MAG_TRK_HIST_EN
      chk({t, ".hist"}, hist, tbl[i].x_hist);
`endif
    end

    // Saturation: 300 consecutive gt samples must stick at the maximum.
    for (int i = 0; i < 300; i++) begin
      cyc(0, 0, 1, 1, 0, 0, 10, 9);
      if (i == 254 || i == 255) chk($sformatf("sat%0d.gt_count", i), gt_count, 255);
    end
    chk("sat.gt_count", gt_count, 255);
    chk("sat.run_len", run_len, 255);
    chk("sat.alarm", alarm, 1);
    chk("sat.run_state", run_state, 1);
    cyc(0, 0, 1, 0, 1, 0, 2, 11);
    chk("sat_break.run_len", run_len, 1);
    chk("sat_break.alarm", alarm, 0);
    chk("sat_break.gt_count", gt_count, 255);

    // Reset in the middle of a run wins over clear and a valid sample.
    cyc(0, 0, 1, 0, 1, 0, 2, 11);
    cyc(1, 1, 1, 0, 1, 0, 2, 11);
    check_model("midreset");
    chk("midreset.run_len", run_len, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit r, c, v, g, l, e;
      int av, bv;
      av = $urandom_range(0, 15);
      bv = $urandom_range(0, 15);
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        {g, l, e} = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 2) == 0) begin
        // favour long runs so the alarm threshold is exercised
        g = 0; l = 1; e = 0; av = 2; bv = 11;
      end else begin
        g = (av > bv); l = (av < bv); e = (av == bv);
      end
      cyc(r, c, v, g, l, e, av, bv);
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mag_comp_tracker.md
Name: mag_comp_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator (mag_comp). Samples each comparator result (a_gt_b / a_lt_b / a_eq_b) together with its operands.
- Keeps saturating per-outcome event counters, the largest "winning" operand seen, and a run-length FSM for consecutive identical outcomes.
- Raises an alarm when a run reaches a programmable limit. Feeds status/debug logic in the Ch 6 dataflow exercises.

Parameters:
- WIDTH, 4, operand width; matches the comparator's a/b.
- CNT_W, 8, width of each event counter and run_len.
- RUN_LIMIT, 3, run length at which alarm asserts; legal range 1..2^CNT_W-1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear of statistics.
- in_valid  input  1  current comparator result is valid this cycle.
- a_gt_b  input  1  comparator flag: a > b.
- a_lt_b  input  1  comparator flag: a < b.
- a_eq_b  input  1  comparator flag: a == b.
- a  input  WIDTH  operand A as presented to the comparator.
- b  input  WIDTH  operand B as presented to the comparator.
- gt_count  output  CNT_W  number of accepted gt results, saturating.
- lt_count  output  CNT_W  number of accepted lt results, saturating.
- eq_count  output  CNT_W  number of accepted eq results, saturating.
- max_val  output  WIDTH  largest winner seen since reset/clear.
- max_valid  output  1  max_val holds at least one sample.
- run_state  output  2  FSM state: 00 IDLE, 01 GT_RUN, 10 LT_RUN, 11 EQ_RUN.
- run_len  output  CNT_W  length of the current run, saturating.
- alarm  output  1  high while run_len >= RUN_LIMIT.
- err  output  1  sticky: a non-one-hot flag set was seen with in_valid.

Behaviour:
- Clock/reset: one clock, clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: counters 0, max_val 0, max_valid 0, run_state IDLE, run_len 0, alarm 0, err 0.
- Priority: reset > clear > sample.
  - clear resets everything that reset does except err; err is cleared only by reset.
  - clear together with in_valid: clear wins and the sample is dropped.
- Acceptance: a sample is accepted when in_valid=1 and exactly one of {a_gt_b, a_lt_b, a_eq_b} is 1.
  - Results reflect the accepted sample on the cycle after the accepting edge (1-cycle latency).
- Illegal flags: in_valid=1 with zero or more than one flag set:
  - err <= 1.
  - No counter, max or FSM update.
  - The sample is treated as absent.
- in_valid=0: all state holds.
- Counters: the matching counter increments by 1 and saturates at 2^CNT_W-1. No wrap.
- Winner and max:
  - Winner is a if gt, b if lt, a if eq.
  - If max_valid=0, max_val <= winner and max_valid <= 1.
  - Otherwise max_val <= winner only if winner > max_val (unsigned compare).
- FSM:
  - IDLE + accepted X -> X_RUN, run_len <= 1.
  - X_RUN + accepted X -> stay, run_len <= run_len+1, saturating.
  - X_RUN + accepted Y (Y != X) -> Y_RUN, run_len <= 1.
  - No accepted sample -> hold state and run_len.
  - IDLE is reachable only via reset or clear.
- alarm is a combinational decode of registered run_len (run_len >= RUN_LIMIT). With RUN_LIMIT=1, alarm is high whenever run_state != IDLE.
- Reset mid-run: next edge returns to the reset values regardless of the other inputs.

Optional Feature:
- Macro MAG_TRK_HIST_EN.
- When defined:
  - Adds output hist (8 bits): a shift register of the last four accepted outcomes, 2-bit codes as in run_state, newest in bits [1:0].
  - Shifts only on an accepted sample.
  - Cleared to 0 by reset and by clear.
- When undefined: the hist port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, a=10, b=9, a_gt_b=1 -> all outputs equal reset values; err=0.
- Sequence with in_valid=1, one sample per cycle:
  - Samples: (10,9,gt), (1,6,lt), (2,11,lt), (15,15,eq).
  - Expected: gt_count=1, lt_count=2, eq_count=1, max_val=15, max_valid=1, run_state=11, run_len=1, alarm=0.
  - With MAG_TRK_HIST_EN: hist=8'b01_10_10_11 (oldest to newest: gt, lt, lt, eq; newest in [1:0]).
- Run alarm: three consecutive (2,11,lt) after reset -> run_len 1,2,3; alarm rises on the cycle after the third accepted edge. A following (15,15,eq) drops alarm and sets run_len=1.
- Saturation: CNT_W=8, 300 consecutive gt samples -> gt_count=255, run_len=255, alarm=1; no wrap.
- Illegal flags: in_valid=1 with a_gt_b=a_eq_b=1 -> err=1; counters and run_state unchanged.
  - Then clear -> err stays 1, counters 0.
  - Then reset -> err=0.
- Clear collision: clear=1 with in_valid=1, (10,9,gt) after a nonzero history -> all counters 0, run_state IDLE, max_valid=0; the sample is not counted.
